// File: rtl/mem_port_arbiter_if.sv
// Fetch/data request and unified-memory bus bundle
// for mem_port_arbiter; slave is the arbiter side.
interface mem_port_arbiter_if;
   logic        IReqF;
   logic [31:0] PCF;
   logic [31:0] InstrF;
   logic        IValidF;
   logic        StallF;
   logic        DReqM;
   logic        MemWriteM;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [31:0] ReadDataM;
   logic        DValidM;
   logic        StallM;
   logic        MemReq;
   logic        MemWe;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic [31:0] MemRData;

   modport slave (
      input  IReqF, PCF, DReqM, MemWriteM,
      input  ALUResultM, WriteDataM, MemRData,
      output InstrF, IValidF, StallF,
      output ReadDataM, DValidM, StallM,
      output MemReq, MemWe, MemAddr, MemWData
   );

   modport master (
      output IReqF, PCF, DReqM, MemWriteM,
      output ALUResultM, WriteDataM, MemRData,
      input  InstrF, IValidF, StallF,
      input  ReadDataM, DValidM, StallM,
      input  MemReq, MemWe, MemAddr, MemWData
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a fixed-latency unified memory.
// MEM_ARB_RR_EN: strict alternation on contested grants.
module mem_port_arbiter #(
   parameter int unsigned LATENCY     = 2,
   parameter int unsigned MAX_DSTREAK = 4
) (
   input logic clk,
   input logic reset,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE, ISSUE, WAIT, DONE
   } state_t;

   state_t      state;
   state_t      state_n;
   logic        grant;
   logic        pick_d;
   logic        capture;
   logic        owner_d;
   logic        we_q;
   logic [3:0]  cnt;

`ifdef MEM_ARB_RR_EN
   logic        last_f;

   assign pick_d = bus.DReqM
                 & (~bus.IReqF | last_f);
`else
   logic [3:0]  streak;

   assign pick_d = bus.DReqM
                 & ~(bus.IReqF
                 & (streak == 4'(MAX_DSTREAK)));
`endif

   assign capture = (state == WAIT)
                 && (cnt == 4'd1);

   assign bus.StallF = bus.IReqF & ~bus.IValidF;
   assign bus.StallM = bus.DReqM & ~bus.DValidM;

   // Next-state: arbitrate only in IDLE
   always_comb begin
      state_n = state;
      grant   = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.IReqF | bus.DReqM) begin
               grant   = 1'b1;
               state_n = ISSUE;
            end
         end
         ISSUE: state_n = WAIT;
         WAIT: begin
            if (cnt == 4'd1)
               state_n = DONE;
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_n;
   end

   // Latency countdown, loaded while MemReq is out
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= 4'd0;
      else if (state == ISSUE)
         cnt <= 4'(LATENCY);
      else if (state == WAIT)
         cnt <= cnt - 4'd1;
   end

   // Memory request: one-cycle pulse after a grant
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.MemReq   <= 1'b0;
         bus.MemWe    <= 1'b0;
         bus.MemAddr  <= 32'd0;
         bus.MemWData <= 32'd0;
         owner_d      <= 1'b0;
         we_q         <= 1'b0;
      end else begin
         bus.MemReq <= grant;
         bus.MemWe  <= grant & pick_d
                     & bus.MemWriteM;
         if (grant) begin
            owner_d     <= pick_d;
            we_q        <= pick_d & bus.MemWriteM;
            bus.MemAddr <= pick_d ? bus.ALUResultM
                                  : bus.PCF;
            if (pick_d & bus.MemWriteM)
               bus.MemWData <= bus.WriteDataM;
         end
      end
   end

   // Grant history for contested arbitration
`ifdef MEM_ARB_RR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last_f <= 1'b1;
      else if (grant)
         last_f <= ~pick_d;
   end
`else
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         streak <= 4'd0;
      else if (grant) begin
         if (pick_d & bus.IReqF)
            streak <= streak + 4'd1;
         else
            streak <= 4'd0;
      end
   end
`endif

   // Capture read data and raise the owner's valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.InstrF    <= 32'd0;
         bus.ReadDataM <= 32'd0;
         bus.IValidF   <= 1'b0;
         bus.DValidM   <= 1'b0;
      end else begin
         bus.IValidF <= capture & ~owner_d;
         bus.DValidM <= capture & owner_d;
         if (capture & ~owner_d)
            bus.InstrF <= bus.MemRData;
         if (capture & owner_d & ~we_q)
            bus.ReadDataM <= bus.MemRData;
      end
   end

endmodule
